// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file for the miniRV pipeline.
// Commits MEM/WB results into x1..x31, serves two decode read ports with
// write-first bypass, mirrors the commit onto the trace interface, and keeps
// retired-instruction/cycle counters plus a sticky pipeline-hang flag.
module wb_regfile #(
    parameter int unsigned HANG_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rf_we,
    input  logic [4:0]  wR,
    input  logic [31:0] wD,
    input  logic [31:0] debug_pc,
    input  logic        debug_have_inst,
    input  logic [4:0]  rR1,
    input  logic [4:0]  rR2,
    output logic [31:0] rD1,
    output logic [31:0] rD2,
    output logic        debug_wb_have_inst,
    output logic [31:0] debug_wb_pc,
    output logic        debug_wb_ena,
    output logic [4:0]  debug_wb_reg,
    output logic [31:0] debug_wb_value,
    output logic [63:0] instret_o,
    output logic [63:0] cycle_o,
    output logic        hang_o
);

    // x0 has no storage; writes to it are filtered by wr_en.
    logic [31:0] regs_q [31:1];
    logic [63:0] instret_q;
    logic [63:0] cycle_q;
    logic [31:0] idle_q;
    logic [31:0] idle_d;
    logic        hang_q;
    logic        hang_d;
    logic        wr_en;

    assign wr_en = rf_we && (wR != 5'd0);

    // Register storage: x1..x31, written on commit of a non-x0 destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wR] <= wD;
        end
    end

    // Read port 1: x0 reads zero, same-cycle write is bypassed ahead of storage.
    always_comb begin
        rD1 = '0;
        if (rR1 != 5'd0) begin
            if (wr_en && (wR == rR1)) begin
                rD1 = wD;
            end else begin
                rD1 = regs_q[rR1];
            end
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rD2 = '0;
        if (rR2 != 5'd0) begin
            if (wr_en && (wR == rR2)) begin
                rD2 = wD;
            end else begin
                rD2 = regs_q[rR2];
            end
        end
    end

    // Hang detector next state: idle counter saturates at the limit, flag is sticky.
    always_comb begin
        idle_d = idle_q;
        hang_d = hang_q;
        if (debug_have_inst) begin
            idle_d = '0;
        end else begin
            if (idle_q != HANG_LIMIT) begin
                idle_d = idle_q + 32'd1;
            end
            if (idle_q == HANG_LIMIT - 32'd1) begin
                hang_d = 1'b1;
            end
        end
    end

    // Counters and hang state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
            cycle_q   <= '0;
            idle_q    <= '0;
            hang_q    <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (debug_have_inst) begin
                instret_q <= instret_q + 64'd1;
            end
            idle_q <= idle_d;
            hang_q <= hang_d;
        end
    end

    assign instret_o = instret_q;
    assign cycle_o   = cycle_q;
    assign hang_o    = hang_q;

    // Commit trace: direct copy of the WB inputs, no added latency.
    assign debug_wb_have_inst = debug_have_inst;
    assign debug_wb_pc        = debug_pc;
    assign debug_wb_ena       = debug_have_inst && wr_en;
    assign debug_wb_reg       = wR;
    assign debug_wb_value     = wD;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios with literal
// expectations, then randomized commits checked every cycle against a
// behavioural model of the register file, counters and hang flag.
module tb_wb_regfile;

    localparam int unsigned HL = 4;

    logic        clk;
    logic        rst_n;
    logic        rf_we;
    logic [4:0]  wR;
    logic [31:0] wD;
    logic [31:0] debug_pc;
    logic        debug_have_inst;
    logic [4:0]  rR1;
    logic [4:0]  rR2;
    logic [31:0] rD1;
    logic [31:0] rD2;
    logic        debug_wb_have_inst;
    logic [31:0] debug_wb_pc;
    logic        debug_wb_ena;
    logic [4:0]  debug_wb_reg;
    logic [31:0] debug_wb_value;
    logic [63:0] instret_o;
    logic [63:0] cycle_o;
    logic        hang_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    wb_regfile #(.HANG_LIMIT(HL)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rf_we             (rf_we),
        .wR                (wR),
        .wD                (wD),
        .debug_pc          (debug_pc),
        .debug_have_inst   (debug_have_inst),
        .rR1               (rR1),
        .rR2               (rR2),
        .rD1               (rD1),
        .rD2               (rD2),
        .debug_wb_have_inst(debug_wb_have_inst),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_ena      (debug_wb_ena),
        .debug_wb_reg      (debug_wb_reg),
        .debug_wb_value    (debug_wb_value),
        .instret_o         (instret_o),
        .cycle_o           (cycle_o),
        .hang_o            (hang_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: plain array of 32 registers, unbounded idle-run length.
    logic [31:0]     m_regs [32];
    longint unsigned m_instret;
    longint unsigned m_cycle;
    longint unsigned m_idle;
    bit              m_hang;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
            m_instret <= 0;
            m_cycle   <= 0;
            m_idle    <= 0;
            m_hang    <= 1'b0;
        end else begin
            if (rf_we && wR != 5'd0) m_regs[wR] <= wD;
            m_cycle <= m_cycle + 1;
            if (debug_have_inst) begin
                m_instret <= m_instret + 1;
                m_idle    <= 0;
            end else begin
                m_idle <= m_idle + 1;
                if (m_idle + 1 >= HL) m_hang <= 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (rf_we && wR == idx) return wD;
        return m_regs[idx];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rD1", {32'd0, rD1}, {32'd0, exp_rd(rR1)});
            chk("rD2", {32'd0, rD2}, {32'd0, exp_rd(rR2)});
            chk("wb_have", {63'd0, debug_wb_have_inst}, {63'd0, debug_have_inst});
            chk("wb_ena", {63'd0, debug_wb_ena},
                {63'd0, (debug_have_inst && rf_we && wR != 5'd0)});
            chk("wb_pc", {32'd0, debug_wb_pc}, {32'd0, debug_pc});
            chk("wb_reg", {59'd0, debug_wb_reg}, {59'd0, wR});
            chk("wb_value", {32'd0, debug_wb_value}, {32'd0, wD});
            chk("instret", instret_o, m_instret);
            chk("cycle", cycle_o, m_cycle);
            chk("hang", {63'd0, hang_o}, {63'd0, m_hang});
        end
    end

    task automatic quiet_inputs();
        rf_we = 1'b0; wR = '0; wD = '0; debug_pc = '0; debug_have_inst = 1'b0;
    endtask

    initial begin
        int burst;
        rst_n = 1'b0;
        quiet_inputs();
        rR1 = '0; rR2 = '0;
        repeat (2) @(posedge clk);

        // Reset release and cycle counting.
        #2 rst_n = 1'b1; rR1 = 5'd5; rR2 = 5'd0; cmp_en = 1;
        #1;
        chk("rst_rD1", {32'd0, rD1}, 64'd0);
        chk("rst_rD2", {32'd0, rD2}, 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        chk("rst_hang", {63'd0, hang_o}, 64'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #3;
            chk("cycle_step", cycle_o, 64'(k));
        end

        // Write 0xDEADBEEF to x7 after 3 idle edges: bypass, then storage.
        rf_we = 1'b1; wR = 5'd7; wD = 32'hDEADBEEF; debug_have_inst = 1'b1;
        debug_pc = 32'h0000_0040; rR1 = 5'd7;
        #1;
        chk("bypass_x7", {32'd0, rD1}, 64'h0000_0000_DEAD_BEEF);
        chk("ena_x7", {63'd0, debug_wb_ena}, 64'd1);
        @(posedge clk); #3;
        rf_we = 1'b0; debug_have_inst = 1'b0;
        #1;
        chk("stored_x7", {32'd0, rD1}, 64'h0000_0000_DEAD_BEEF);
        chk("instret_one", instret_o, 64'd1);
        chk("no_hang_3idle", {63'd0, hang_o}, 64'd0);

        // x0 write is dropped.
        @(posedge clk); #3;
        rf_we = 1'b1; wR = 5'd0; wD = 32'h12345678; debug_have_inst = 1'b1; rR1 = 5'd0;
        #1;
        chk("x0_bypass", {32'd0, rD1}, 64'd0);
        chk("x0_ena", {63'd0, debug_wb_ena}, 64'd0);
        @(posedge clk); #3;
        rf_we = 1'b0; debug_have_inst = 1'b0;
        #1;
        chk("x0_stored", {32'd0, rD1}, 64'd0);

        // Dual-port bypass over a stored value.
        rf_we = 1'b1; wR = 5'd3; wD = 32'h11; debug_have_inst = 1'b1;
        @(posedge clk); #3;
        wD = 32'h22; rR1 = 5'd3; rR2 = 5'd3;
        #1;
        chk("dual_rD1", {32'd0, rD1}, 64'h22);
        chk("dual_rD2", {32'd0, rD2}, 64'h22);
        rR1 = 5'd4;
        #1;
        chk("dual_x4", {32'd0, rD1}, 64'd0);
        @(posedge clk); #3;
        rf_we = 1'b0; debug_have_inst = 1'b0;
        #1;
        chk("dual_stored", {32'd0, rD2}, 64'h22);

        // Ten back-to-back commits to x1..x10.
        for (int i = 1; i <= 10; i++) begin
            rf_we = 1'b1; wR = 5'(i); wD = 32'(i * 3); debug_have_inst = 1'b1;
            debug_pc = 32'h100 + 32'(4 * i);
            #1;
            chk("b2b_pc", {32'd0, debug_wb_pc}, 64'(32'h100 + 4 * i));
            chk("b2b_reg", {59'd0, debug_wb_reg}, 64'(i));
            chk("b2b_value", {32'd0, debug_wb_value}, 64'(i * 3));
            @(posedge clk); #3;
        end
        rf_we = 1'b0;
        #1;
        chk("b2b_instret", instret_o, 64'd14);
        // Read-back in commit cycles that write nothing, keeping the idle run short.
        for (int i = 1; i <= 10; i++) begin
            rR1 = 5'(i); rR2 = 5'(11 - i); debug_have_inst = 1'b1;
            #1;
            chk("b2b_rd1", {32'd0, rD1}, 64'(i * 3));
            chk("b2b_rd2", {32'd0, rD2}, 64'((11 - i) * 3));
            @(posedge clk); #3;
        end
        chk("read_instret", instret_o, 64'd24);

        // Hang detector: limit 4 idle edges, sticky across a commit.
        debug_have_inst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #3;
            chk("hang_low", {63'd0, hang_o}, 64'd0);
        end
        @(posedge clk); #3;
        chk("hang_set", {63'd0, hang_o}, 64'd1);
        debug_have_inst = 1'b1;
        @(posedge clk); #3;
        debug_have_inst = 1'b0;
        chk("hang_sticky", {63'd0, hang_o}, 64'd1);
        chk("hang_instret", instret_o, 64'd25);

        // Asynchronous reset mid-cycle clears everything at once.
        rR1 = 5'd7; rR2 = 5'd10;
        rst_n = 1'b0;
        #1;
        chk("arst_hang", {63'd0, hang_o}, 64'd0);
        chk("arst_instret", instret_o, 64'd0);
        chk("arst_cycle", cycle_o, 64'd0);
        chk("arst_x7", {32'd0, rD1}, 64'd0);
        chk("arst_x10", {32'd0, rD2}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Randomized commits with idle bursts and occasional reset pulses.
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            rst_n = ($urandom_range(0, 299) != 0);
            rf_we = ($urandom_range(0, 3) != 0);
            wR = 5'($urandom_range(0, 31));
            wD = $urandom;
            debug_pc = $urandom;
            if (burst > 0) begin
                debug_have_inst = 1'b0;
                burst--;
            end else begin
                debug_have_inst = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 49) == 0) burst = $urandom_range(2, 6);
            end
            rR1 = ($urandom_range(0, 3) == 0) ? wR : 5'($urandom_range(0, 31));
            rR2 = ($urandom_range(0, 3) == 0) ? wR : 5'($urandom_range(0, 31));
        end
        @(posedge clk); #2;
        cmp_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
